// File: rtl/washer_pkg.sv
// Shared constants for the washer front-panel conditioner: key indices,
// default debounce/beep timing and the released key level.
package washer_pkg;
  localparam int KEY_SELECT = 0;
  localparam int KEY_START  = 1;
  localparam int KEY_EMERG  = 2;
  localparam int NUM_KEYS   = 3;

  localparam int DB_CYCLES_DEF   = 3;
  localparam int BEEP_CYCLES_DEF = 4;

  localparam logic KEY_RELEASED = 1'b1;

  typedef logic [NUM_KEYS-1:0] key_vec_t;
endpackage

// File: rtl/key_debounce.sv
// One panel key: 2-flop synchronizer, stability counter and debounced level.
// key_armed stays low after reset until the key has been seen released.
module key_debounce
  import washer_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic key_db,
  output logic key_armed
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_q, db_d;
  logic          armed_q, armed_d;
  logic [1:0]    fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = '0;
    if (sync2_q != db_q) begin
      if (cnt_q == CNT_LAST) begin
        db_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    // sync2 only reflects the pin once the reset values have shifted out
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & sync2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= KEY_RELEASED;
      sync2_q <= KEY_RELEASED;
      db_q    <= KEY_RELEASED;
      cnt_q   <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      db_q    <= db_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign key_db    = db_q;
  assign key_armed = armed_q;
endmodule

// File: rtl/washer_panel.sv
// Front-panel key conditioner and buzzer driver for the washer controller.
// Define WASHER_PANEL_BEEP_EN to add a key-click on accepted select/start presses.
module washer_panel
  import washer_pkg::*;
#(
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int BEEP_CYCLES = BEEP_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic key_select_raw,
  input  logic key_start_raw,
  input  logic key_emerg_raw,
  input  logic done,
  input  logic alarm,
  output logic select,
  output logic start,
  output logic emergency,
  output logic buzzer
);
  localparam int BW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_CYCLES - 1);

  key_vec_t      key_raw, key_db, key_armed, press;
  key_vec_t      prev_q, prev_d;
  logic          select_q, select_d;
  logic          start_q, start_d;
  logic          emergency_q, emergency_d;
  logic          buzzer_q, buzzer_d;
  logic          alarm_q;
  logic          start_tog, click_on;
  logic [BW-1:0] beep_cnt_q, beep_cnt_d;

  assign key_raw[KEY_SELECT] = key_select_raw;
  assign key_raw[KEY_START]  = key_start_raw;
  assign key_raw[KEY_EMERG]  = key_emerg_raw;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key (
      .clk      (clk),
      .rst_n    (rst),
      .key_raw  (key_raw[g]),
      .key_db   (key_db[g]),
      .key_armed(key_armed[g])
    );
  end

  assign press = key_armed & prev_q & ~key_db;

  // Rules see the emergency level being registered this edge, so a stop
  // clears start in the same cycle emergency drops.
  always_comb begin
    prev_d      = key_db;
    emergency_d = key_db[KEY_EMERG];
    select_d    = press[KEY_SELECT] & ~start_q & emergency_d;
    start_tog   = press[KEY_START] & emergency_d;
    if (!emergency_d || done) begin
      start_d = 1'b0;
    end else begin
      start_d = start_q ^ start_tog;
    end
  end

  always_comb begin
    beep_cnt_d = beep_cnt_q;
    buzzer_d   = click_on;
    if (alarm) begin
      if (!alarm_q) begin
        buzzer_d   = 1'b1;
        beep_cnt_d = BEEP_LAST;
      end else if (beep_cnt_q == '0) begin
        buzzer_d   = ~buzzer_q;
        beep_cnt_d = BEEP_LAST;
      end else begin
        buzzer_d   = buzzer_q;
        beep_cnt_d = beep_cnt_q - 1'b1;
      end
    end
  end

`ifdef WASHER_PANEL_BEEP_EN
  logic          click_start;
  logic [BW-1:0] click_cnt_q, click_cnt_d;

  // The press cycle itself is the first click cycle; the counter covers the rest.
  always_comb begin
    click_start = select_d | (start_tog & ~done);
    click_on    = click_start | (click_cnt_q != '0);
    if (click_start) begin
      click_cnt_d = BEEP_LAST;
    end else if (click_cnt_q != '0) begin
      click_cnt_d = click_cnt_q - 1'b1;
    end else begin
      click_cnt_d = click_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      click_cnt_q <= '0;
    end else begin
      click_cnt_q <= click_cnt_d;
    end
  end
`else
  assign click_on = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q      <= {NUM_KEYS{KEY_RELEASED}};
      select_q    <= 1'b0;
      start_q     <= 1'b0;
      emergency_q <= KEY_RELEASED;
      buzzer_q    <= 1'b0;
      alarm_q     <= 1'b0;
      beep_cnt_q  <= '0;
    end else begin
      prev_q      <= prev_d;
      select_q    <= select_d;
      start_q     <= start_d;
      emergency_q <= emergency_d;
      buzzer_q    <= buzzer_d;
      alarm_q     <= alarm;
      beep_cnt_q  <= beep_cnt_d;
    end
  end

  assign select    = select_q;
  assign start     = start_q;
  assign emergency = emergency_q;
  assign buzzer    = buzzer_q;
endmodule

// File: tb/tb_washer_panel.sv
// Scoreboard bench for washer_panel: directed panel scenarios plus random key
// bouncing, checked cycle by cycle against a window-based reference model.
module tb_washer_panel;
  import washer_pkg::*;

  localparam int DB   = DB_CYCLES_DEF;
  localparam int BEEP = BEEP_CYCLES_DEF;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic key_select_raw = 1'b1, key_start_raw = 1'b1, key_emerg_raw = 1'b1;
  logic done = 1'b0, alarm = 1'b0;
  logic select, start, emergency, buzzer;

  washer_panel #(.DB_CYCLES(DB), .BEEP_CYCLES(BEEP)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_select_raw(key_select_raw),
    .key_start_raw (key_start_raw),
    .key_emerg_raw (key_emerg_raw),
    .done          (done),
    .alarm         (alarm),
    .select        (select),
    .start         (start),
    .emergency     (emergency),
    .buzzer        (buzzer)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // expected {select, start, emergency, buzzer} after each rising edge
  logic [3:0] exp_q[$];

  // reference model state
  logic [2:0] pin_hist[$];   // raw samples still travelling through the synchronizer
  logic [2:0] sync_win[$];   // last DB synchronized samples seen by the debouncer
  logic [2:0] deb_m, deb_prev_m, armed_m;
  logic       start_m;
  int         edge_idx, alarm_run, click_left;

  function automatic void model_reset();
    pin_hist.delete();
    pin_hist.push_back(3'b111);
    pin_hist.push_back(3'b111);
    sync_win.delete();
    deb_m      = 3'b111;
    deb_prev_m = 3'b111;
    armed_m    = 3'b000;
    start_m    = 1'b0;
    edge_idx   = 0;
    alarm_run  = 0;
    click_left = 0;
  endfunction

  function automatic logic [3:0] model_edge(input logic [2:0] r, input logic d, input logic a);
    logic [2:0] s_now, press, deb_next;
    logic       em, sel, tog, bz, click_on, all_differ;
    s_now = pin_hist[0];
    press = armed_m & deb_prev_m & ~deb_m;
    em    = deb_m[KEY_EMERG];
    sel   = press[KEY_SELECT] & ~start_m & em;
    tog   = press[KEY_START] & em;
    if (!em || d) start_m = 1'b0;
    else if (tog) start_m = ~start_m;
    alarm_run = a ? alarm_run + 1 : 0;
`ifdef WASHER_PANEL_BEEP_EN
    if (sel || (tog && !d)) click_left = BEEP;
`endif
    click_on = (click_left > 0);
    if (click_left > 0) click_left--;
    bz = a ? ((((alarm_run - 1) / BEEP) % 2) == 0) : click_on;
    // a key level is accepted once DB consecutive synchronized samples disagree with it
    sync_win.push_back(s_now);
    if (sync_win.size() > DB) void'(sync_win.pop_front());
    deb_next = deb_m;
    if (sync_win.size() == DB) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        all_differ = 1'b1;
        for (int j = 0; j < DB; j++) if (sync_win[j][k] == deb_m[k]) all_differ = 1'b0;
        if (all_differ) deb_next[k] = s_now[k];
      end
    end
    if (edge_idx >= 2) armed_m = armed_m | s_now;
    deb_prev_m = deb_m;
    deb_m      = deb_next;
    pin_hist.push_back(r);
    void'(pin_hist.pop_front());
    edge_idx++;
    return {sel, start_m, em, bz};
  endfunction

  // keys: bit KEY_SELECT / KEY_START / KEY_EMERG, 0 = pressed
  task automatic step(input logic [2:0] keys, input logic d, input logic a, input logic rn);
    logic [3:0] e;
    @(negedge clk);
    key_select_raw = keys[KEY_SELECT];
    key_start_raw  = keys[KEY_START];
    key_emerg_raw  = keys[KEY_EMERG];
    done  = d;
    alarm = a;
    rst   = rn;
    if (!rn) begin
      model_reset();
      e = 4'b0010;
    end else begin
      e = model_edge(keys, d, a);
    end
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic [2:0] keys, input logic d, input logic a, input int n);
    for (int i = 0; i < n; i++) step(keys, d, a, 1'b1);
  endtask

  initial begin : monitor
    logic [3:0] e, got;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {select, start, emergency, buzzer};
        total++;
        if (got !== e) begin
          bad++;
          $display("FAIL outputs t=%0t sel/start/emg/buz got=%b want=%b", $time, got, e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         left[3];
    int         alarm_left;
    logic [2:0] lvl;
    logic       alm;
    model_reset();
    for (int i = 0; i < 10; i++) step(3'($urandom_range(0, 7)), 1'b0, 1'b0, 1'b0);
    hold(3'b111, 0, 0, 6);
    // bounce shorter than the debounce window, then a clean press
    hold(3'b110, 0, 0, 2);
    hold(3'b111, 0, 0, 10);
    hold(3'b110, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    // start on, select blocked, start off, start on
    hold(3'b101, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    hold(3'b110, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    hold(3'b101, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    hold(3'b101, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    // emergency stop, start key ignored while held, then restart
    hold(3'b011, 0, 0, 10);
    hold(3'b001, 0, 0, 10);
    hold(3'b011, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    hold(3'b101, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    // turn start off, then a press whose toggle lands on a done cycle
    hold(3'b101, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    hold(3'b101, 0, 0, 5);
    step(3'b101, 1'b1, 1'b0, 1'b1);
    hold(3'b101, 0, 0, 4);
    hold(3'b111, 0, 0, 10);
    // alarm square wave and its release
    hold(3'b111, 0, 1, 20);
    hold(3'b111, 0, 0, 5);
    // select held through a mid-operation reset
    hold(3'b110, 0, 0, 3);
    step(3'b110, 1'b0, 1'b0, 1'b0);
    step(3'b110, 1'b0, 1'b0, 1'b0);
    hold(3'b110, 0, 0, 15);
    hold(3'b111, 0, 0, 10);
    hold(3'b110, 0, 0, 10);
    hold(3'b111, 0, 0, 10);
    // random bouncing keys, sporadic done, alarm bursts, rare resets
    lvl = 3'b111;
    alm = 1'b0;
    alarm_left = $urandom_range(5, 40);
    for (int k = 0; k < NUM_KEYS; k++) left[k] = $urandom_range(1, 10);
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (left[k] == 0) begin
          lvl[k] = ~lvl[k];
          if (k == KEY_EMERG && lvl[k]) left[k] = $urandom_range(10, 60);
          else left[k] = $urandom_range(1, 14);
        end
        left[k]--;
      end
      if (alarm_left == 0) begin
        alm = ~alm;
        alarm_left = alm ? $urandom_range(1, 25) : $urandom_range(5, 60);
      end
      alarm_left--;
      step(lvl, ($urandom_range(0, 29) == 0), alm, !($urandom_range(0, 499) == 0));
    end
    hold(3'b111, 0, 0, 3);
    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
